aes_sbox_word: RTL and testbench

//  Applies the AES forward S-box (FIPS-197 SubBytes) to each byte of a 32-bit word.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_sbox_byte.sv | 104 ++++++++++
 rtl/aes_sbox_word.sv | 62 ++++++
 tb/tb_aes_sbox_word.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, the forward and inverse S-box tables and a lookup helper.
// The inverse table and the inv argument of sbox_lookup only matter when
// AES_SBOX_INV_EN is defined; the default build selects the forward table.
package aes_pkg;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_word_t;

  // Element 0 sits at the most significant end, so the hex reads in table order.
  localparam logic [0:255][7:0] AES_SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] AES_SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Table lookup for a single byte; inv=1 picks InvSubBytes.
  function automatic aes_byte_t sbox_lookup(input aes_byte_t b, input logic inv);
    return inv ? AES_SBOX_INV[b] : AES_SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational AES S-box for one byte, written as a 256-entry case table.
// With AES_SBOX_INV_EN defined an inverse table is built too and inv_i picks
// between them; otherwise only the forward table exists.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
`ifdef AES_SBOX_INV_EN
  input  logic      inv_i,
`endif
  output aes_byte_t byte_o
);

  aes_byte_t fwd_b;

  // Forward S-box (SubBytes).
  always_comb begin
    fwd_b = 8'h00;
    case (byte_i)
      8'h00: fwd_b = 8'h63; 8'h01: fwd_b = 8'h7c; 8'h02: fwd_b = 8'h77; 8'h03: fwd_b = 8'h7b; 8'h04: fwd_b = 8'hf2; 8'h05: fwd_b = 8'h6b; 8'h06: fwd_b = 8'h6f; 8'h07: fwd_b = 8'hc5;
      8'h08: fwd_b = 8'h30; 8'h09: fwd_b = 8'h01; 8'h0a: fwd_b = 8'h67; 8'h0b: fwd_b = 8'h2b; 8'h0c: fwd_b = 8'hfe; 8'h0d: fwd_b = 8'hd7; 8'h0e: fwd_b = 8'hab; 8'h0f: fwd_b = 8'h76;
      8'h10: fwd_b = 8'hca; 8'h11: fwd_b = 8'h82; 8'h12: fwd_b = 8'hc9; 8'h13: fwd_b = 8'h7d; 8'h14: fwd_b = 8'hfa; 8'h15: fwd_b = 8'h59; 8'h16: fwd_b = 8'h47; 8'h17: fwd_b = 8'hf0;
      8'h18: fwd_b = 8'had; 8'h19: fwd_b = 8'hd4; 8'h1a: fwd_b = 8'ha2; 8'h1b: fwd_b = 8'haf; 8'h1c: fwd_b = 8'h9c; 8'h1d: fwd_b = 8'ha4; 8'h1e: fwd_b = 8'h72; 8'h1f: fwd_b = 8'hc0;
      8'h20: fwd_b = 8'hb7; 8'h21: fwd_b = 8'hfd; 8'h22: fwd_b = 8'h93; 8'h23: fwd_b = 8'h26; 8'h24: fwd_b = 8'h36; 8'h25: fwd_b = 8'h3f; 8'h26: fwd_b = 8'hf7; 8'h27: fwd_b = 8'hcc;
      8'h28: fwd_b = 8'h34; 8'h29: fwd_b = 8'ha5; 8'h2a: fwd_b = 8'he5; 8'h2b: fwd_b = 8'hf1; 8'h2c: fwd_b = 8'h71; 8'h2d: fwd_b = 8'hd8; 8'h2e: fwd_b = 8'h31; 8'h2f: fwd_b = 8'h15;
      8'h30: fwd_b = 8'h04; 8'h31: fwd_b = 8'hc7; 8'h32: fwd_b = 8'h23; 8'h33: fwd_b = 8'hc3; 8'h34: fwd_b = 8'h18; 8'h35: fwd_b = 8'h96; 8'h36: fwd_b = 8'h05; 8'h37: fwd_b = 8'h9a;
      8'h38: fwd_b = 8'h07; 8'h39: fwd_b = 8'h12; 8'h3a: fwd_b = 8'h80; 8'h3b: fwd_b = 8'he2; 8'h3c: fwd_b = 8'heb; 8'h3d: fwd_b = 8'h27; 8'h3e: fwd_b = 8'hb2; 8'h3f: fwd_b = 8'h75;
      8'h40: fwd_b = 8'h09; 8'h41: fwd_b = 8'h83; 8'h42: fwd_b = 8'h2c; 8'h43: fwd_b = 8'h1a; 8'h44: fwd_b = 8'h1b; 8'h45: fwd_b = 8'h6e; 8'h46: fwd_b = 8'h5a; 8'h47: fwd_b = 8'ha0;
      8'h48: fwd_b = 8'h52; 8'h49: fwd_b = 8'h3b; 8'h4a: fwd_b = 8'hd6; 8'h4b: fwd_b = 8'hb3; 8'h4c: fwd_b = 8'h29; 8'h4d: fwd_b = 8'he3; 8'h4e: fwd_b = 8'h2f; 8'h4f: fwd_b = 8'h84;
      8'h50: fwd_b = 8'h53; 8'h51: fwd_b = 8'hd1; 8'h52: fwd_b = 8'h00; 8'h53: fwd_b = 8'hed; 8'h54: fwd_b = 8'h20; 8'h55: fwd_b = 8'hfc; 8'h56: fwd_b = 8'hb1; 8'h57: fwd_b = 8'h5b;
      8'h58: fwd_b = 8'h6a; 8'h59: fwd_b = 8'hcb; 8'h5a: fwd_b = 8'hbe; 8'h5b: fwd_b = 8'h39; 8'h5c: fwd_b = 8'h4a; 8'h5d: fwd_b = 8'h4c; 8'h5e: fwd_b = 8'h58; 8'h5f: fwd_b = 8'hcf;
      8'h60: fwd_b = 8'hd0; 8'h61: fwd_b = 8'hef; 8'h62: fwd_b = 8'haa; 8'h63: fwd_b = 8'hfb; 8'h64: fwd_b = 8'h43; 8'h65: fwd_b = 8'h4d; 8'h66: fwd_b = 8'h33; 8'h67: fwd_b = 8'h85;
      8'h68: fwd_b = 8'h45; 8'h69: fwd_b = 8'hf9; 8'h6a: fwd_b = 8'h02; 8'h6b: fwd_b = 8'h7f; 8'h6c: fwd_b = 8'h50; 8'h6d: fwd_b = 8'h3c; 8'h6e: fwd_b = 8'h9f; 8'h6f: fwd_b = 8'ha8;
      8'h70: fwd_b = 8'h51; 8'h71: fwd_b = 8'ha3; 8'h72: fwd_b = 8'h40; 8'h73: fwd_b = 8'h8f; 8'h74: fwd_b = 8'h92; 8'h75: fwd_b = 8'h9d; 8'h76: fwd_b = 8'h38; 8'h77: fwd_b = 8'hf5;
      8'h78: fwd_b = 8'hbc; 8'h79: fwd_b = 8'hb6; 8'h7a: fwd_b = 8'hda; 8'h7b: fwd_b = 8'h21; 8'h7c: fwd_b = 8'h10; 8'h7d: fwd_b = 8'hff; 8'h7e: fwd_b = 8'hf3; 8'h7f: fwd_b = 8'hd2;
      8'h80: fwd_b = 8'hcd; 8'h81: fwd_b = 8'h0c; 8'h82: fwd_b = 8'h13; 8'h83: fwd_b = 8'hec; 8'h84: fwd_b = 8'h5f; 8'h85: fwd_b = 8'h97; 8'h86: fwd_b = 8'h44; 8'h87: fwd_b = 8'h17;
      8'h88: fwd_b = 8'hc4; 8'h89: fwd_b = 8'ha7; 8'h8a: fwd_b = 8'h7e; 8'h8b: fwd_b = 8'h3d; 8'h8c: fwd_b = 8'h64; 8'h8d: fwd_b = 8'h5d; 8'h8e: fwd_b = 8'h19; 8'h8f: fwd_b = 8'h73;
      8'h90: fwd_b = 8'h60; 8'h91: fwd_b = 8'h81; 8'h92: fwd_b = 8'h4f; 8'h93: fwd_b = 8'hdc; 8'h94: fwd_b = 8'h22; 8'h95: fwd_b = 8'h2a; 8'h96: fwd_b = 8'h90; 8'h97: fwd_b = 8'h88;
      8'h98: fwd_b = 8'h46; 8'h99: fwd_b = 8'hee; 8'h9a: fwd_b = 8'hb8; 8'h9b: fwd_b = 8'h14; 8'h9c: fwd_b = 8'hde; 8'h9d: fwd_b = 8'h5e; 8'h9e: fwd_b = 8'h0b; 8'h9f: fwd_b = 8'hdb;
      8'ha0: fwd_b = 8'he0; 8'ha1: fwd_b = 8'h32; 8'ha2: fwd_b = 8'h3a; 8'ha3: fwd_b = 8'h0a; 8'ha4: fwd_b = 8'h49; 8'ha5: fwd_b = 8'h06; 8'ha6: fwd_b = 8'h24; 8'ha7: fwd_b = 8'h5c;
      8'ha8: fwd_b = 8'hc2; 8'ha9: fwd_b = 8'hd3; 8'haa: fwd_b = 8'hac; 8'hab: fwd_b = 8'h62; 8'hac: fwd_b = 8'h91; 8'had: fwd_b = 8'h95; 8'hae: fwd_b = 8'he4; 8'haf: fwd_b = 8'h79;
      8'hb0: fwd_b = 8'he7; 8'hb1: fwd_b = 8'hc8; 8'hb2: fwd_b = 8'h37; 8'hb3: fwd_b = 8'h6d; 8'hb4: fwd_b = 8'h8d; 8'hb5: fwd_b = 8'hd5; 8'hb6: fwd_b = 8'h4e; 8'hb7: fwd_b = 8'ha9;
      8'hb8: fwd_b = 8'h6c; 8'hb9: fwd_b = 8'h56; 8'hba: fwd_b = 8'hf4; 8'hbb: fwd_b = 8'hea; 8'hbc: fwd_b = 8'h65; 8'hbd: fwd_b = 8'h7a; 8'hbe: fwd_b = 8'hae; 8'hbf: fwd_b = 8'h08;
      8'hc0: fwd_b = 8'hba; 8'hc1: fwd_b = 8'h78; 8'hc2: fwd_b = 8'h25; 8'hc3: fwd_b = 8'h2e; 8'hc4: fwd_b = 8'h1c; 8'hc5: fwd_b = 8'ha6; 8'hc6: fwd_b = 8'hb4; 8'hc7: fwd_b = 8'hc6;
      8'hc8: fwd_b = 8'he8; 8'hc9: fwd_b = 8'hdd; 8'hca: fwd_b = 8'h74; 8'hcb: fwd_b = 8'h1f; 8'hcc: fwd_b = 8'h4b; 8'hcd: fwd_b = 8'hbd; 8'hce: fwd_b = 8'h8b; 8'hcf: fwd_b = 8'h8a;
      8'hd0: fwd_b = 8'h70; 8'hd1: fwd_b = 8'h3e; 8'hd2: fwd_b = 8'hb5; 8'hd3: fwd_b = 8'h66; 8'hd4: fwd_b = 8'h48; 8'hd5: fwd_b = 8'h03; 8'hd6: fwd_b = 8'hf6; 8'hd7: fwd_b = 8'h0e;
      8'hd8: fwd_b = 8'h61; 8'hd9: fwd_b = 8'h35; 8'hda: fwd_b = 8'h57; 8'hdb: fwd_b = 8'hb9; 8'hdc: fwd_b = 8'h86; 8'hdd: fwd_b = 8'hc1; 8'hde: fwd_b = 8'h1d; 8'hdf: fwd_b = 8'h9e;
      8'he0: fwd_b = 8'he1; 8'he1: fwd_b = 8'hf8; 8'he2: fwd_b = 8'h98; 8'he3: fwd_b = 8'h11; 8'he4: fwd_b = 8'h69; 8'he5: fwd_b = 8'hd9; 8'he6: fwd_b = 8'h8e; 8'he7: fwd_b = 8'h94;
      8'he8: fwd_b = 8'h9b; 8'he9: fwd_b = 8'h1e; 8'hea: fwd_b = 8'h87; 8'heb: fwd_b = 8'he9; 8'hec: fwd_b = 8'hce; 8'hed: fwd_b = 8'h55; 8'hee: fwd_b = 8'h28; 8'hef: fwd_b = 8'hdf;
      8'hf0: fwd_b = 8'h8c; 8'hf1: fwd_b = 8'ha1; 8'hf2: fwd_b = 8'h89; 8'hf3: fwd_b = 8'h0d; 8'hf4: fwd_b = 8'hbf; 8'hf5: fwd_b = 8'he6; 8'hf6: fwd_b = 8'h42; 8'hf7: fwd_b = 8'h68;
      8'hf8: fwd_b = 8'h41; 8'hf9: fwd_b = 8'h99; 8'hfa: fwd_b = 8'h2d; 8'hfb: fwd_b = 8'h0f; 8'hfc: fwd_b = 8'hb0; 8'hfd: fwd_b = 8'h54; 8'hfe: fwd_b = 8'hbb; 8'hff: fwd_b = 8'h16;
      default: fwd_b = 8'h00;
    endcase
  end

`ifdef AES_SBOX_INV_EN
  aes_byte_t inv_b;

  // Inverse S-box (InvSubBytes).
  always_comb begin
    inv_b = 8'h00;
    case (byte_i)
      8'h00: inv_b = 8'h52; 8'h01: inv_b = 8'h09; 8'h02: inv_b = 8'h6a; 8'h03: inv_b = 8'hd5; 8'h04: inv_b = 8'h30; 8'h05: inv_b = 8'h36; 8'h06: inv_b = 8'ha5; 8'h07: inv_b = 8'h38;
      8'h08: inv_b = 8'hbf; 8'h09: inv_b = 8'h40; 8'h0a: inv_b = 8'ha3; 8'h0b: inv_b = 8'h9e; 8'h0c: inv_b = 8'h81; 8'h0d: inv_b = 8'hf3; 8'h0e: inv_b = 8'hd7; 8'h0f: inv_b = 8'hfb;
      8'h10: inv_b = 8'h7c; 8'h11: inv_b = 8'he3; 8'h12: inv_b = 8'h39; 8'h13: inv_b = 8'h82; 8'h14: inv_b = 8'h9b; 8'h15: inv_b = 8'h2f; 8'h16: inv_b = 8'hff; 8'h17: inv_b = 8'h87;
      8'h18: inv_b = 8'h34; 8'h19: inv_b = 8'h8e; 8'h1a: inv_b = 8'h43; 8'h1b: inv_b = 8'h44; 8'h1c: inv_b = 8'hc4; 8'h1d: inv_b = 8'hde; 8'h1e: inv_b = 8'he9; 8'h1f: inv_b = 8'hcb;
      8'h20: inv_b = 8'h54; 8'h21: inv_b = 8'h7b; 8'h22: inv_b = 8'h94; 8'h23: inv_b = 8'h32; 8'h24: inv_b = 8'ha6; 8'h25: inv_b = 8'hc2; 8'h26: inv_b = 8'h23; 8'h27: inv_b = 8'h3d;
      8'h28: inv_b = 8'hee; 8'h29: inv_b = 8'h4c; 8'h2a: inv_b = 8'h95; 8'h2b: inv_b = 8'h0b; 8'h2c: inv_b = 8'h42; 8'h2d: inv_b = 8'hfa; 8'h2e: inv_b = 8'hc3; 8'h2f: inv_b = 8'h4e;
      8'h30: inv_b = 8'h08; 8'h31: inv_b = 8'h2e; 8'h32: inv_b = 8'ha1; 8'h33: inv_b = 8'h66; 8'h34: inv_b = 8'h28; 8'h35: inv_b = 8'hd9; 8'h36: inv_b = 8'h24; 8'h37: inv_b = 8'hb2;
      8'h38: inv_b = 8'h76; 8'h39: inv_b = 8'h5b; 8'h3a: inv_b = 8'ha2; 8'h3b: inv_b = 8'h49; 8'h3c: inv_b = 8'h6d; 8'h3d: inv_b = 8'h8b; 8'h3e: inv_b = 8'hd1; 8'h3f: inv_b = 8'h25;
      8'h40: inv_b = 8'h72; 8'h41: inv_b = 8'hf8; 8'h42: inv_b = 8'hf6; 8'h43: inv_b = 8'h64; 8'h44: inv_b = 8'h86; 8'h45: inv_b = 8'h68; 8'h46: inv_b = 8'h98; 8'h47: inv_b = 8'h16;
      8'h48: inv_b = 8'hd4; 8'h49: inv_b = 8'ha4; 8'h4a: inv_b = 8'h5c; 8'h4b: inv_b = 8'hcc; 8'h4c: inv_b = 8'h5d; 8'h4d: inv_b = 8'h65; 8'h4e: inv_b = 8'hb6; 8'h4f: inv_b = 8'h92;
      8'h50: inv_b = 8'h6c; 8'h51: inv_b = 8'h70; 8'h52: inv_b = 8'h48; 8'h53: inv_b = 8'h50; 8'h54: inv_b = 8'hfd; 8'h55: inv_b = 8'hed; 8'h56: inv_b = 8'hb9; 8'h57: inv_b = 8'hda;
      8'h58: inv_b = 8'h5e; 8'h59: inv_b = 8'h15; 8'h5a: inv_b = 8'h46; 8'h5b: inv_b = 8'h57; 8'h5c: inv_b = 8'ha7; 8'h5d: inv_b = 8'h8d; 8'h5e: inv_b = 8'h9d; 8'h5f: inv_b = 8'h84;
      8'h60: inv_b = 8'h90; 8'h61: inv_b = 8'hd8; 8'h62: inv_b = 8'hab; 8'h63: inv_b = 8'h00; 8'h64: inv_b = 8'h8c; 8'h65: inv_b = 8'hbc; 8'h66: inv_b = 8'hd3; 8'h67: inv_b = 8'h0a;
      8'h68: inv_b = 8'hf7; 8'h69: inv_b = 8'he4; 8'h6a: inv_b = 8'h58; 8'h6b: inv_b = 8'h05; 8'h6c: inv_b = 8'hb8; 8'h6d: inv_b = 8'hb3; 8'h6e: inv_b = 8'h45; 8'h6f: inv_b = 8'h06;
      8'h70: inv_b = 8'hd0; 8'h71: inv_b = 8'h2c; 8'h72: inv_b = 8'h1e; 8'h73: inv_b = 8'h8f; 8'h74: inv_b = 8'hca; 8'h75: inv_b = 8'h3f; 8'h76: inv_b = 8'h0f; 8'h77: inv_b = 8'h02;
      8'h78: inv_b = 8'hc1; 8'h79: inv_b = 8'haf; 8'h7a: inv_b = 8'hbd; 8'h7b: inv_b = 8'h03; 8'h7c: inv_b = 8'h01; 8'h7d: inv_b = 8'h13; 8'h7e: inv_b = 8'h8a; 8'h7f: inv_b = 8'h6b;
      8'h80: inv_b = 8'h3a; 8'h81: inv_b = 8'h91; 8'h82: inv_b = 8'h11; 8'h83: inv_b = 8'h41; 8'h84: inv_b = 8'h4f; 8'h85: inv_b = 8'h67; 8'h86: inv_b = 8'hdc; 8'h87: inv_b = 8'hea;
      8'h88: inv_b = 8'h97; 8'h89: inv_b = 8'hf2; 8'h8a: inv_b = 8'hcf; 8'h8b: inv_b = 8'hce; 8'h8c: inv_b = 8'hf0; 8'h8d: inv_b = 8'hb4; 8'h8e: inv_b = 8'he6; 8'h8f: inv_b = 8'h73;
      8'h90: inv_b = 8'h96; 8'h91: inv_b = 8'hac; 8'h92: inv_b = 8'h74; 8'h93: inv_b = 8'h22; 8'h94: inv_b = 8'he7; 8'h95: inv_b = 8'had; 8'h96: inv_b = 8'h35; 8'h97: inv_b = 8'h85;
      8'h98: inv_b = 8'he2; 8'h99: inv_b = 8'hf9; 8'h9a: inv_b = 8'h37; 8'h9b: inv_b = 8'he8; 8'h9c: inv_b = 8'h1c; 8'h9d: inv_b = 8'h75; 8'h9e: inv_b = 8'hdf; 8'h9f: inv_b = 8'h6e;
      8'ha0: inv_b = 8'h47; 8'ha1: inv_b = 8'hf1; 8'ha2: inv_b = 8'h1a; 8'ha3: inv_b = 8'h71; 8'ha4: inv_b = 8'h1d; 8'ha5: inv_b = 8'h29; 8'ha6: inv_b = 8'hc5; 8'ha7: inv_b = 8'h89;
      8'ha8: inv_b = 8'h6f; 8'ha9: inv_b = 8'hb7; 8'haa: inv_b = 8'h62; 8'hab: inv_b = 8'h0e; 8'hac: inv_b = 8'haa; 8'had: inv_b = 8'h18; 8'hae: inv_b = 8'hbe; 8'haf: inv_b = 8'h1b;
      8'hb0: inv_b = 8'hfc; 8'hb1: inv_b = 8'h56; 8'hb2: inv_b = 8'h3e; 8'hb3: inv_b = 8'h4b; 8'hb4: inv_b = 8'hc6; 8'hb5: inv_b = 8'hd2; 8'hb6: inv_b = 8'h79; 8'hb7: inv_b = 8'h20;
      8'hb8: inv_b = 8'h9a; 8'hb9: inv_b = 8'hdb; 8'hba: inv_b = 8'hc0; 8'hbb: inv_b = 8'hfe; 8'hbc: inv_b = 8'h78; 8'hbd: inv_b = 8'hcd; 8'hbe: inv_b = 8'h5a; 8'hbf: inv_b = 8'hf4;
      8'hc0: inv_b = 8'h1f; 8'hc1: inv_b = 8'hdd; 8'hc2: inv_b = 8'ha8; 8'hc3: inv_b = 8'h33; 8'hc4: inv_b = 8'h88; 8'hc5: inv_b = 8'h07; 8'hc6: inv_b = 8'hc7; 8'hc7: inv_b = 8'h31;
      8'hc8: inv_b = 8'hb1; 8'hc9: inv_b = 8'h12; 8'hca: inv_b = 8'h10; 8'hcb: inv_b = 8'h59; 8'hcc: inv_b = 8'h27; 8'hcd: inv_b = 8'h80; 8'hce: inv_b = 8'hec; 8'hcf: inv_b = 8'h5f;
      8'hd0: inv_b = 8'h60; 8'hd1: inv_b = 8'h51; 8'hd2: inv_b = 8'h7f; 8'hd3: inv_b = 8'ha9; 8'hd4: inv_b = 8'h19; 8'hd5: inv_b = 8'hb5; 8'hd6: inv_b = 8'h4a; 8'hd7: inv_b = 8'h0d;
      8'hd8: inv_b = 8'h2d; 8'hd9: inv_b = 8'he5; 8'hda: inv_b = 8'h7a; 8'hdb: inv_b = 8'h9f; 8'hdc: inv_b = 8'h93; 8'hdd: inv_b = 8'hc9; 8'hde: inv_b = 8'h9c; 8'hdf: inv_b = 8'hef;
      8'he0: inv_b = 8'ha0; 8'he1: inv_b = 8'he0; 8'he2: inv_b = 8'h3b; 8'he3: inv_b = 8'h4d; 8'he4: inv_b = 8'hae; 8'he5: inv_b = 8'h2a; 8'he6: inv_b = 8'hf5; 8'he7: inv_b = 8'hb0;
      8'he8: inv_b = 8'hc8; 8'he9: inv_b = 8'heb; 8'hea: inv_b = 8'hbb; 8'heb: inv_b = 8'h3c; 8'hec: inv_b = 8'h83; 8'hed: inv_b = 8'h53; 8'hee: inv_b = 8'h99; 8'hef: inv_b = 8'h61;
      8'hf0: inv_b = 8'h17; 8'hf1: inv_b = 8'h2b; 8'hf2: inv_b = 8'h04; 8'hf3: inv_b = 8'h7e; 8'hf4: inv_b = 8'hba; 8'hf5: inv_b = 8'h77; 8'hf6: inv_b = 8'hd6; 8'hf7: inv_b = 8'h26;
      8'hf8: inv_b = 8'he1; 8'hf9: inv_b = 8'h69; 8'hfa: inv_b = 8'h14; 8'hfb: inv_b = 8'h63; 8'hfc: inv_b = 8'h55; 8'hfd: inv_b = 8'h21; 8'hfe: inv_b = 8'h0c; 8'hff: inv_b = 8'h7d;
      default: inv_b = 8'h00;
    endcase
  end

  assign byte_o = inv_i ? inv_b : fwd_b;
`else
  assign byte_o = fwd_b;
`endif

endmodule

// File: rtl/aes_sbox_word.sv
// AES SubWord / SubBytes on a 32-bit word: four independent byte-lane S-boxes
// followed by a single output register, so results appear one cycle later.
// Optional feature: AES_SBOX_INV_EN adds i_inv to pick the inverse S-box; the
// choice is captured together with the word.
//
// Handshake: i_vld qualifies i_wrd_sbox (and i_inv) in the cycle it is high;
// there is no ready, every valid word is accepted. o_vld is i_vld delayed by
// one cycle and qualifies o_wrd_sbox; o_wrd_sbox keeps its last loaded value
// while no new word arrives.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_vld,
  input  aes_word_t i_wrd_sbox,
`ifdef AES_SBOX_INV_EN
  input  logic      i_inv,
`endif
  output logic      o_vld,
  output aes_word_t o_wrd_sbox
);

  aes_word_t sub_wrd;
  aes_word_t wrd_d;
  aes_word_t wrd_q;
  logic      vld_q;

  // One lookup per lane; lanes never exchange bytes.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    aes_sbox_byte u_sbox (
      .byte_i (i_wrd_sbox[8*k +: 8]),
`ifdef AES_SBOX_INV_EN
      .inv_i  (i_inv),
`endif
      .byte_o (sub_wrd[8*k +: 8])
    );
  end

  // Next data value: take the substituted word only when a word is offered.
  always_comb begin
    wrd_d = wrd_q;
    if (i_vld) begin
      wrd_d = sub_wrd;
    end
  end

  // Output register and valid pipeline; reset wins over a simultaneous i_vld.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wrd_q <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      wrd_q <= wrd_d;
      vld_q <= i_vld;
    end
  end

  assign o_wrd_sbox = wrd_q;
  assign o_vld      = vld_q;

endmodule

// File: tb/tb_aes_sbox_word.sv
// Bench for aes_sbox_word. Reference S-box values come from a GF(2^8)
// inverse plus the FIPS-197 affine map, built at time zero. The inverse-table
// checks run only when AES_SBOX_INV_EN is defined.
module tb_aes_sbox_word;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic [31:0] wrd;
  logic        inv;
  logic        o_vld;
  logic [31:0] o_wrd;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  fwd_m [256];
  logic [7:0]  inv_m [256];
  logic [31:0] exp_q [$];
  logic [31:0] exp_hold;

  typedef struct {
    logic        vld;
    logic [31:0] wrd;
    logic [31:0] exp_wrd;
    logic        exp_vld;
  } vec_t;

  vec_t vecs [11];

  aes_sbox_word dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_vld      (vld),
    .i_wrd_sbox (wrd),
`ifdef AES_SBOX_INV_EN
    .i_inv      (inv),
`endif
    .o_vld      (o_vld),
    .o_wrd_sbox (o_wrd)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic build_model();
    logic [7:0] iv;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      end
      fwd_m[x] = affine(iv);
    end
    for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w, input logic i);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = i ? inv_m[w[8*k +: 8]] : fwd_m[w[8*k +: 8]];
    return r;
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] w, input logic iv);
    @(negedge clk);
    vld = v;
    wrd = w;
    inv = iv;
  endtask

  // Scoreboard comparison after the active edge
  task automatic check_out(input string name, input logic [31:0] ew, input logic ev);
    @(posedge clk);
    #1;
    checks++;
    if (o_wrd !== ew || o_vld !== ev) begin
      failures++;
      $display("FAIL %s: got wrd=%08h vld=%b, want wrd=%08h vld=%b", name, o_wrd, o_vld, ew, ev);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = 1'b1;
    wrd   = 32'hFFFFFFFF;
    inv   = 1'b0;
    build_model();

    vecs[0]  = '{1'b1, 32'h00010253, 32'h637C77ED, 1'b1};
    vecs[1]  = '{1'b1, 32'hFFFFFFFF, 32'h16161616, 1'b1};
    vecs[2]  = '{1'b0, 32'h00000000, 32'h16161616, 1'b0};
    vecs[3]  = '{1'b0, 32'hA5A5A5A5, 32'h16161616, 1'b0};
    vecs[4]  = '{1'b1, 32'h10101010, 32'hCACACACA, 1'b1};
    vecs[5]  = '{1'b1, 32'h53535353, 32'hEDEDEDED, 1'b1};
    vecs[6]  = '{1'b1, 32'h00000000, 32'h63636363, 1'b1};
    vecs[7]  = '{1'b0, 32'h12345678, 32'h63636363, 1'b0};
    vecs[8]  = '{1'b1, 32'h01234567, 32'h7C266E85, 1'b1};
    vecs[9]  = '{1'b1, 32'h89ABCDEF, 32'hA762BDDF, 1'b1};
    vecs[10] = '{1'b1, 32'hFE8C0F1F, 32'hBB6476C0, 1'b1};

    // Reset held two cycles with a valid all-ones word on the input
    check_out("reset_c1", 32'h0, 1'b0);
    check_out("reset_c2", 32'h0, 1'b0);

    // Directed table, consecutive cycles
    @(negedge clk);
    rst_n = 1'b1;
    vld   = vecs[0].vld;
    wrd   = vecs[0].wrd;
    check_out("vec0", vecs[0].exp_wrd, vecs[0].exp_vld);
    for (int i = 1; i < 11; i++) begin
      drive(vecs[i].vld, vecs[i].wrd, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].exp_wrd, vecs[i].exp_vld);
    end

    // Reset in mid-stream overrides a valid input
    drive(1'b1, 32'hFFFFFFFF, 1'b0);
    rst_n = 1'b0;
    check_out("mid_reset", 32'h0, 1'b0);
    drive(1'b0, 32'h00000000, 1'b0);
    rst_n = 1'b1;
    check_out("post_reset_idle", 32'h0, 1'b0);

    // Sweep of every byte value in every lane, back-to-back
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      logic [31:0] w;
      b = 8'(v);
      w = {b + 8'd128, ~b, b ^ 8'h5A, b};
      drive(1'b1, w, 1'b0);
      exp_q.push_back({fwd_m[w[31:24]], fwd_m[w[23:16]], fwd_m[w[15:8]], fwd_m[w[7:0]]});
      check_out("sweep", exp_q.pop_front(), 1'b1);
    end

    // Random words with random valid gaps
    exp_hold = {fwd_m[8'd255 + 8'd128], fwd_m[8'h00], fwd_m[8'hFF ^ 8'h5A], fwd_m[8'hFF]};
    for (int n = 0; n < 200; n++) begin
      logic        rv;
      logic [31:0] rw;
      rv = ($urandom_range(0, 3) != 0);
      rw = $urandom;
      drive(rv, rw, 1'b0);
      if (rv) exp_hold = model_word(rw, 1'b0);
      check_out("random", exp_hold, rv);
    end

`ifdef AES_SBOX_INV_EN
    drive(1'b1, 32'h637C77ED, 1'b1);
    check_out("inv_known", 32'h00010253, 1'b1);
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      logic [31:0] w;
      b = 8'(v);
      w = {b ^ 8'h3C, b + 8'd64, ~b, b};
      drive(1'b1, w, 1'b1);
      check_out("inv_sweep", model_word(w, 1'b1), 1'b1);
    end
    for (int n = 0; n < 50; n++) begin
      logic [31:0] rw;
      rw = $urandom;
      drive(1'b1, rw, 1'b0);
      check_out("rt_fwd", model_word(rw, 1'b0), 1'b1);
      drive(1'b1, model_word(rw, 1'b0), 1'b1);
      check_out("rt_inv", rw, 1'b1);
    end
`endif

    // Final report
    drive(1'b0, 32'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
